reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port register file for the processor datapath. It generalises the 32-way combinational read select into a clocked storage array: one write port and NUM_RD independent registered read ports. Reads have one-cycle latency and write-to-read bypass. Register 0 can optionally be hard-wired to zero. It sits between decode and execute, feeding operand registers directly.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2^ADDR_W registers.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: when 1, register 0 always reads 0 and writes to it are discarded.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- re  in  NUM_RD  per-port read enable; bit i belongs to port i.
- raddr  in  NUM_RD*ADDR_W  read addresses; port i is raddr[i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  registered read data; port i is rdata[i*DATA_W +: DATA_W].
- rvalid  out  NUM_RD  per-port pulse: rdata of port i was updated on the last edge.

## Operation
- Storage: 2^ADDR_W registers of DATA_W bits. No unreachable addresses exist.
- Write: on a rising edge with we=1, the register at waddr takes wdata.
  - Exception: ZERO_REG=1 and waddr=0, in which case the write is dropped.
- Read, port i: on a rising edge with re[i]=1, rdata_i is loaded and rvalid[i] is set to 1.
- With re[i]=0, rdata_i holds its previous value and rvalid[i] goes to 0.
- The value loaded on a read is chosen in priority order:
  - 0, when ZERO_REG=1 and raddr_i=0.
  - wdata (bypass), when we=1 and waddr=raddr_i in the same cycle. The new value is returned, never the stale one.
  - Otherwise the array content at raddr_i.
- Multiple ports may read the same address in the same cycle. Each gets identical data, with bypass applied per port independently.
- No per-port state machine; each port is a single register stage with a hold-enable.
- Reset (rst_n=0, any time, asynchronous):
  - All array registers clear to 0.
  - All rdata clear to 0.
  - All rvalid clear to 0.
  - A write or read in flight during the reset cycle is lost.
  - The first edge with rst_n=1 operates normally.

## Timing
- Write-to-array latency: 1 edge. A read issued on the edge after the write sees the new value from the array.
- A read issued on the same edge as the write sees it through the bypass.
- Read latency: raddr/re sampled at edge N; rdata/rvalid valid after edge N, stable until edge N+1.
- rvalid is a one-cycle pulse per accepted read. Back-to-back re=1 keeps rvalid high continuously.
- Reset values: rdata = 0, rvalid = 0, array = 0. Deassertion needs no synchronisation beyond the system-level reset synchroniser.
- No combinational path from any input to any output.

## Test plan
- Reset, then read every address on both ports -> rdata=0x00000000 and rvalid=1 one cycle after each re.
- Write 0xDEADBEEF to r5, then next cycle read r5 on port 0 -> rdata_0=0xDEADBEEF one cycle later.
- Same-cycle write 0x12345678 to r7 and read r7 on ports 0 and 1 -> both rdata=0x12345678 one cycle later (bypass).
- Write 0xFFFFFFFF to r0 with ZERO_REG=1, then read r0 with a simultaneous write to r0 -> rdata=0x00000000. Repeat with ZERO_REG=0 -> rdata=0xFFFFFFFF.
- Read r3 (holding 0xA5A5A5A5), then drop re for 3 cycles while writing 0x0 to r3 -> rdata_0 holds 0xA5A5A5A5 and rvalid_0=0 during the hold.
- Pulse rst_n low mid-stream after writing r31=0xCAFEF00D -> rdata/rvalid go to 0 immediately without a clock edge, and a later read of r31 returns 0x00000000.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with one write port and NUM_RD registered read ports with write bypass.
// Ports: clk, rst_n (async active-low); we/waddr/wdata write port;
// re/raddr per-port read request; rdata/rvalid per-port registered result and update pulse.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rvalid
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] nxt [NUM_RD];
  logic wen;
  assign wen = we && !(ZERO_REG != 0 && waddr == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    else if (wen) mem[waddr] <= wdata;
  // Hard zero beats bypass so a dropped write to r0 never leaks through.
  always_comb
    for (int p = 0; p < NUM_RD; p++)
      nxt[p] = (ZERO_REG != 0 && raddr[p*ADDR_W +: ADDR_W] == '0) ? '0 :
               (we && waddr == raddr[p*ADDR_W +: ADDR_W]) ? wdata :
               mem[raddr[p*ADDR_W +: ADDR_W]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= re;
      for (int p = 0; p < NUM_RD; p++)
        if (re[p]) rdata[p*DATA_W +: DATA_W] <= nxt[p];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed bench comparing two instances (ZERO_REG=1 and 0) against a behavioural model.
module tb_reg_file_mp;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        we = 0;
  logic [4:0]  waddr = 0;
  logic [31:0] wdata = 0;
  logic [1:0]  re = 0;
  logic [9:0]  raddr = 0;
  logic [63:0] rdata_z, rdata_n;
  logic [1:0]  rvalid_z, rvalid_n;
  int checks = 0;
  int failures = 0;

  reg_file_mp #(.ZERO_REG(1)) dut_z (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_z), .rvalid(rvalid_z));
  reg_file_mp #(.ZERO_REG(0)) dut_n (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_n), .rvalid(rvalid_n));

  always #5 clk = ~clk;

  logic [31:0] mz [32];
  logic [31:0] mn [32];
  logic [31:0] ez [2];
  logic [31:0] en [2];
  logic [1:0]  ev;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 32; k++) begin mz[k] <= 0; mn[k] <= 0; end
      ez[0] <= 0; ez[1] <= 0; en[0] <= 0; en[1] <= 0; ev <= 0;
    end else begin
      ev <= re;
      for (int p = 0; p < 2; p++)
        if (re[p]) begin
          ez[p] <= (raddr[p*5 +: 5] == 0) ? 32'h0 : (we && waddr == raddr[p*5 +: 5]) ? wdata : mz[raddr[p*5 +: 5]];
          en[p] <= (we && waddr == raddr[p*5 +: 5]) ? wdata : mn[raddr[p*5 +: 5]];
        end
      if (we) mn[waddr] <= wdata;
      if (we && waddr != 0) mz[waddr] <= wdata;
    end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_rdata_z", rdata_z, {ez[1], ez[0]});
    chk("model_rdata_n", rdata_n, {en[1], en[0]});
    chk("model_rvalid_z", {62'd0, rvalid_z}, {62'd0, ev});
    chk("model_rvalid_n", {62'd0, rvalid_n}, {62'd0, ev});
  end

  task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [1:0] r, input logic [4:0] a0, input logic [4:0] a1);
    we = w; waddr = wa; wdata = wd; re = r; raddr = {a1, a0};
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rdata_z, 64'h0);
    chk("reset_rvalid", {62'd0, rvalid_z}, 64'h0);
    rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      cyc(0, 0, 0, 2'b11, 5'(a), 5'(a));
      chk("init_read", rdata_n, 64'h0);
      chk("init_rvalid", {62'd0, rvalid_n}, 64'h3);
    end
    cyc(1, 5, 32'hDEADBEEF, 2'b00, 0, 0);
    chk("no_read_rvalid", {62'd0, rvalid_z}, 64'h0);
    cyc(0, 0, 0, 2'b01, 5, 0);
    chk("write_then_read", {32'd0, rdata_z[31:0]}, 64'hDEADBEEF);
    cyc(1, 7, 32'h12345678, 2'b11, 7, 7);
    chk("bypass_both", rdata_z, 64'h12345678_12345678);
    cyc(1, 0, 32'hFFFFFFFF, 2'b00, 0, 0);
    cyc(1, 0, 32'hFFFFFFFF, 2'b11, 0, 0);
    chk("r0_zero", rdata_z, 64'h0);
    chk("r0_nozero", rdata_n, 64'hFFFFFFFF_FFFFFFFF);
    cyc(0, 0, 0, 2'b01, 0, 0);
    chk("r0_zero_arr", {32'd0, rdata_z[31:0]}, 64'h0);
    chk("r0_nozero_arr", {32'd0, rdata_n[31:0]}, 64'hFFFFFFFF);
    cyc(1, 3, 32'hA5A5A5A5, 2'b00, 0, 0);
    cyc(0, 0, 0, 2'b01, 3, 0);
    chk("r3_read", {32'd0, rdata_z[31:0]}, 64'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 3, 32'h0, 2'b00, 3, 3);
      chk("hold_data", {32'd0, rdata_z[31:0]}, 64'hA5A5A5A5);
      chk("hold_rvalid", {62'd0, rvalid_z}, 64'h0);
    end
    cyc(0, 0, 0, 2'b10, 0, 3);
    chk("r3_cleared", {rdata_z[63:32], 32'd0}, 64'h0);
    cyc(1, 31, 32'hCAFEF00D, 2'b00, 0, 0);
    cyc(0, 0, 0, 2'b11, 31, 31);
    chk("r31_read", rdata_z, 64'hCAFEF00D_CAFEF00D);
    we = 0; re = 0;
    rst_n = 0;
    #1;
    chk("async_rdata", rdata_z, 64'h0);
    chk("async_rvalid", {62'd0, rvalid_n}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1;
    cyc(0, 0, 0, 2'b11, 31, 31);
    chk("r31_after_reset", rdata_n, 64'h0);
    chk("r31_after_rvalid", {62'd0, rvalid_z}, 64'h3);
    cyc(1, 9, 32'h0BADF00D, 2'b01, 9, 0);
    cyc(1, 10, 32'h11112222, 2'b11, 9, 10);
    chk("mixed", rdata_n, 64'h11112222_0BADF00D);
    cyc(0, 0, 0, 2'b00, 0, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
